// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FWFT FIFO of retired-instruction records with retire sequence numbering and drop accounting.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [XLEN-1:0]            trace_pc_o,
  output logic [XLEN-1:0]            trace_instr_o,
  output logic [4:0]                 trace_rd_o,
  output logic [XLEN-1:0]            trace_wdata_o,
  output logic [31:0]                trace_seq_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [4:0]      rd_mem [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];
  logic [31:0]     seq_mem [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_q, drop_d;
  logic            pop, push, drop;
  always_comb begin
    pop        = (count_q != '0) && trace_ready_i;
    push       = update_i && ((count_q != CW'(DEPTH)) || pop);
    drop       = update_i && !push;
    head_d     = pop ? head_q + AW'(1) : head_q;
    tail_d     = push ? tail_q + AW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    seq_d      = update_i ? seq_q + 32'd1 : seq_q;
    overflow_d = overflow_q || drop;
    drop_d     = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem[tail_q]    <= pc_i;
      instr_mem[tail_q] <= instr_i;
      rd_mem[tail_q]    <= reg_addr_i;
      wdata_mem[tail_q] <= (reg_addr_i == 5'd0) ? '0 : reg_data_i;
      seq_mem[tail_q]   <= seq_q;
    end
  end
  assign trace_valid_o = (count_q != '0);
  assign trace_pc_o    = pc_mem[head_q];
  assign trace_instr_o = instr_mem[head_q];
  assign trace_rd_o    = rd_mem[head_q];
  assign trace_wdata_o = wdata_mem[head_q];
  assign trace_seq_o   = seq_mem[head_q];
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_q;
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter XLEN, default riscv_pkg::XLEN (32), width of pc, instruction and register data fields.
REQ-002 Parameter DEPTH, default 8, number of trace entries; SHALL be a power of two >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 update_i  input  1  core retire strobe; one instruction retired this cycle.
REQ-006 pc_i  input  XLEN  pc of retired instruction.
REQ-007 instr_i  input  XLEN  encoding of retired instruction.
REQ-008 reg_addr_i  input  5  destination register; 0 = no architectural write.
REQ-009 reg_data_i  input  XLEN  value written to reg_addr_i.
REQ-010 trace_valid_o  output  1  head record available.
REQ-011 trace_ready_i  input  1  consumer accepts head record.
REQ-012 trace_pc_o / trace_instr_o  output  XLEN each  head record pc / instruction.
REQ-013 trace_rd_o  output  5  head record destination register.
REQ-014 trace_wdata_o  output  XLEN  head record write data; 0 when trace_rd_o == 0.
REQ-015 trace_seq_o  output  32  head record retire sequence number.
REQ-016 count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 overflow_o  output  1  sticky: at least one retire dropped since reset.
REQ-018 drop_cnt_o  output  16  number of dropped retires, saturating.

Function
REQ-019 Push = update_i && (count < DEPTH || pop); pop = trace_valid_o && trace_ready_i.
REQ-020 Each push SHALL store {pc_i, instr_i, reg_addr_i, reg_addr_i==0 ? 0 : reg_data_i, seq} at tail; tail pointer wraps DEPTH-1 -> 0.
REQ-021 seq SHALL be an internal 32-bit counter incremented (wrapping) on every cycle with update_i high, whether pushed or dropped; record carries pre-increment value, so first retire after reset has seq 0.
REQ-022 trace_valid_o SHALL equal (count != 0); head fields SHALL present oldest entry combinationally from storage (first-word-fall-through).
REQ-023 Push into empty buffer: trace_valid_o high the cycle after update_i (latency 1); no same-cycle bypass.
REQ-024 Head fields SHALL stay stable while trace_valid_o high and trace_ready_i low.
REQ-025 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-026 Full (count == DEPTH) with update_i and pop same cycle: push accepted, no drop.
REQ-027 Full with update_i and no pop: record discarded, storage unchanged, overflow_o set next cycle, drop_cnt_o increments, holding at 16'hFFFF.
REQ-028 Pop when empty impossible (trace_valid_o low); trace_ready_i ignored when empty.
REQ-029 count_o SHALL be registered, range 0..DEPTH.

Reset
REQ-030 rst_i high at a rising edge SHALL clear pointers, count_o, seq, overflow_o, drop_cnt_o; trace_valid_o low the following cycle.
REQ-031 Reset SHALL take priority over concurrent update_i and pop; records in flight are discarded; storage contents need not be cleared.
REQ-032 Head data outputs undefined content permitted while trace_valid_o low; bench SHALL not check them then.

Verification
REQ-033 Single retire: update_i pulse pc 0x80000000, instr 0x00500093, rd 1, data 5, ready high -> next cycle valid with those fields, seq 0; following cycle valid low, count 0.
REQ-034 x0 write: rd 0, reg_data_i 0xDEADBEEF -> trace_rd_o 0, trace_wdata_o 0.
REQ-035 Backpressure fill: ready low, 10 consecutive retires, DEPTH 8 -> count 8, overflow_o 1, drop_cnt_o 2; draining gives seq 0..7 in order; next retire gets seq 10.
REQ-036 Full plus simultaneous push/pop: count 8, ready high and update_i high one cycle -> count stays 8, drop_cnt_o unchanged, head advances to seq 1.
REQ-037 Streaming: update_i and ready high 20 cycles -> count_o at most 1, 20 records with seq 0..19, pointers wrap cleanly.
REQ-038 Reset mid-operation: count 5, overflow set, assert rst_i one cycle with update_i high -> count 0, overflow 0, drop_cnt 0, next retire seq 0.
